// File: rtl/drum_spi_reader.sv
// drum_spi_reader: SPI mode-0 master that fetches 8-bit drum command frames from
// drum_spi_slave whenever its done flag is raised, then validates and decodes them.
module drum_spi_reader #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       done,
  input  logic       sdi,
  output logic       sck,
  output logic       sdo,
  output logic       load,
  output logic       busy,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic [7:0] cmd_raw,
  output logic       empty_frame,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    RELEASE,
    WAIT_DONE_LOW
  } state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [16:0] TO_LIM   = 17'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic        done_meta, done_sync;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic        tail;
  logic        sck_q;
  logic [7:0]  shreg;
  logic [15:0] tcnt;

  logic        div_end, sck_rise, sck_fall, timeout;

  always_comb begin
    div_end  = (div_cnt == DIV_LAST);
    sck_rise = (state == SHIFT) && !tail && div_end && !sck_q;
    sck_fall = (state == SHIFT) && !tail && div_end && sck_q;
    // Pulse lands TIMEOUT_CYCLES clocks after RELEASE: tcnt is 0 in the first
    // WAIT_DONE_LOW cycle and frame_error is registered one cycle later.
    timeout  = (({1'b0, tcnt} + 17'd2) >= TO_LIM);

    state_next = state;
    case (state)
      IDLE:          if (enable && done_sync) state_next = LOAD;
      LOAD:          if (div_end) state_next = SHIFT;
      SHIFT:         if (tail) state_next = RELEASE;
      RELEASE:       state_next = WAIT_DONE_LOW;
      WAIT_DONE_LOW: if (!done_sync || timeout) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_meta   <= 1'b0;
      done_sync   <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tail        <= 1'b0;
      sck_q       <= 1'b0;
      shreg       <= '0;
      tcnt        <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_raw     <= '0;
      empty_frame <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      done_meta   <= done;
      done_sync   <= done_meta;
      cmd_valid   <= 1'b0;
      empty_frame <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          tail    <= 1'b0;
          sck_q   <= 1'b0;
        end
        LOAD: div_cnt <= div_end ? '0 : div_cnt + 8'd1;
        SHIFT: begin
          if (!tail) begin
            div_cnt <= div_end ? '0 : div_cnt + 8'd1;
            if (sck_rise) begin
              sck_q <= 1'b1;
              shreg <= {shreg[6:0], sdi};
            end
            if (sck_fall) begin
              sck_q   <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) tail <= 1'b1;
            end
          end else begin
            // Decode on the way into RELEASE so results appear as load drops.
            cmd_raw <= shreg;
            if (!shreg[7]) begin
              empty_frame <= 1'b1;
            end else if (shreg[6:4] == 3'b000) begin
              cmd_valid <= 1'b1;
              cmd_code  <= shreg[3:0];
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        RELEASE: begin
          tail <= 1'b0;
          tcnt <= '0;
        end
        WAIT_DONE_LOW: begin
          if (tcnt != '1) tcnt <= tcnt + 16'd1;
          if (done_sync && timeout) frame_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sck  = sck_q;
  assign sdo  = 1'b0;
  assign load = (state == LOAD) || (state == SHIFT);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_drum_spi_reader.sv
// Self-checking bench for drum_spi_reader: a behavioural SPI slave serves queued
// frame bytes and expected decode/timing is derived from the frame rules.
module tb_drum_spi_reader;

  localparam int unsigned DIV      = 2;
  localparam int unsigned TO       = 50;
  localparam int unsigned LOAD_LEN = 17 * DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n, enable, done, sdi;
  logic       sck, sdo, load, busy, cmd_valid, empty_frame, frame_error;
  logic [3:0] cmd_code;
  logic [7:0] cmd_raw;

  drum_spi_reader #(.CLK_DIV(DIV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .done(done), .sdi(sdi),
    .sck(sck), .sdo(sdo), .load(load), .busy(busy), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cmd_raw(cmd_raw), .empty_frame(empty_frame),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Slave: MSB presented when load rises, next bit after each sck fall.
  logic [7:0] txq[$];
  logic [7:0] tx_sr = 8'h00;
  assign sdi = tx_sr[7];

  initial begin : slave
    forever begin
      @(posedge load);
      if (txq.size() > 0) tx_sr = txq.pop_front();
      else                tx_sr = 8'h00;
      while (load) begin
        @(negedge sck or negedge load);
        if (load) tx_sr = {tx_sr[6:0], 1'b0};
      end
    end
  end

  int unsigned sck_rises = 0, n_valid = 0, n_empty = 0, n_err = 0;
  logic        sck_prev = 1'b0;
  logic [3:0]  codes[$];

  always @(negedge clk) begin
    if (sck && !sck_prev) sck_rises <= sck_rises + 1;
    sck_prev <= sck;
    if (cmd_valid) begin
      n_valid <= n_valid + 1;
      codes.push_back(cmd_code);
    end
    if (empty_frame) n_empty <= n_empty + 1;
    if (frame_error) n_err <= n_err + 1;
  end

  int unsigned n_cmp = 0, n_bad = 0;
  logic [3:0]  m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [7:0] b, input int unsigned exp_lat,
                          input bit hold, input bit drop_en);
    int unsigned lat, width, r0, e0, n;
    logic exp_v, exp_e, exp_x;
    exp_v = b[7] && (b[6:4] == 3'b000);
    exp_e = !b[7];
    exp_x = b[7] && (b[6:4] != 3'b000);
    if (exp_v) m_code = b[3:0];
    txq.push_back(b);
    done = 1'b1;
    lat = 0;
    while (!load && lat < 40) begin step(); lat++; end
    check("done_to_load", lat, exp_lat);
    if (drop_en) enable = 1'b0;
    r0 = sck_rises;
    width = 0;
    while (load && width < 200) begin step(); width++; end
    check("load_width", width, LOAD_LEN);
    check("sck_rises", sck_rises - r0, 8);
    check("decode_pulses", 32'({cmd_valid, empty_frame, frame_error}), 32'({exp_v, exp_e, exp_x}));
    check("cmd_raw", 32'(cmd_raw), 32'(b));
    check("cmd_code", 32'(cmd_code), 32'(m_code));
    step();
    check("pulse_one_cycle", 32'({cmd_valid, empty_frame, frame_error}), 0);
    if (hold) begin
      n = 1;
      while (!frame_error && n < 100) begin step(); n++; end
      check("timeout_delay", n, TO);
      check("idle_after_timeout", 32'(busy), 0);
    end else begin
      e0 = n_err;
      repeat (9) step();
      done = 1'b0;
      n = 0;
      while (busy && n < 100) begin step(); n++; end
      check("return_idle", 32'(busy), 0);
      check("no_timeout_err", n_err - e0, 0);
    end
  endtask

  initial begin
    int unsigned n, r0, p0, c0;
    logic        any_load;
    logic [7:0]  b;

    rst_n  = 1'b0;
    enable = 1'b1;
    done   = 1'b0;
    m_code = 4'h0;
    repeat (3) step();
    check("reset_outputs",
          32'({sck, sdo, load, busy, cmd_valid, cmd_code, cmd_raw, empty_frame, frame_error}), 0);
    rst_n = 1'b1;
    step();

    do_frame(8'h85, 3, 1'b0, 1'b0);
    do_frame(8'h00, 3, 1'b0, 1'b0);
    do_frame(8'hB3, 3, 1'b0, 1'b0);

    do_frame(8'h8A, 3, 1'b1, 1'b0);
    do_frame(8'h07, 1, 1'b0, 1'b0);

    txq.push_back(8'h8C);
    done = 1'b1;
    n = 0;
    while (!load && n < 40) begin step(); n++; end
    r0 = sck_rises;
    n = 0;
    while ((sck_rises - r0) < 4 && n < 200) begin step(); n++; end
    step();
    check("mid_frame_load", 32'(load), 1);
    p0 = n_valid + n_empty + n_err;
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({load, sck, busy, cmd_valid, empty_frame, frame_error}), 0);
    check("rst_clears_data", 32'({cmd_code, cmd_raw}), 0);
    m_code = 4'h0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_no_pulse", n_valid + n_empty + n_err - p0, 0);
    do_frame(8'h86, 3, 1'b0, 1'b0);

    do_frame(8'h84, 3, 1'b0, 1'b1);
    done = 1'b1;
    any_load = 1'b0;
    repeat (100) begin step(); any_load = any_load | load; end
    check("gate_no_load", 32'(any_load), 0);
    c0 = codes.size();
    enable = 1'b1;
    do_frame(8'h81, 1, 1'b0, 1'b0);
    do_frame(8'h8F, 3, 1'b0, 1'b0);
    check("b2b_count", codes.size() - c0, 2);
    check("b2b_first", 32'(codes[c0]), 1);
    check("b2b_second", 32'(codes[c0 + 1]), 15);

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) b[6:4] = 3'b000;
      do_frame(b, 3, 1'b0, 1'b0);
    end

    check("sdo_zero", 32'(sdo), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
